// File: rtl/no_lut_k.sv
`default_nettype none
// ============================================================================
// Module   : no_lut_k
// Function : K-input Boolean-network node with slow (s0) and fast (s1)
//            trajectories, step counter and s0==s1 match flag.
//            Define NO_LUT_CFG_EN to allow runtime truth-table loading.
// Revision : 1.0 - initial release
// ============================================================================
module no_lut_k #(
    parameter int                  K           = 2,
    parameter logic [(2**K)-1:0]   TRUTH_TABLE = '0,
    parameter int                  CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reset_nos,
    input  logic                 init_state,
    input  logic                 start_s0,
    input  logic                 start_s1,
    input  logic [K-1:0]         nb_s0,
    input  logic [K-1:0]         nb_s1,
    input  logic                 cfg_we,
    input  logic [(2**K)-1:0]    cfg_lut,
    output logic                 s0,
    output logic                 s1,
    output logic                 match,
    output logic [CNT_W-1:0]     step_cnt,
    output logic                 step_sat
);

    localparam int c_LUT_W = 2**K;

    logic [c_LUT_W-1:0] w_lut;
    logic               r_s0;
    logic               r_s1;
    logic               r_pass;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_sat;

`ifdef NO_LUT_CFG_EN
    logic [c_LUT_W-1:0] r_lut;

    // Starts in the load cycle still index the pre-edge table.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lut <= TRUTH_TABLE;
        end else if (cfg_we) begin
            r_lut <= cfg_lut;
        end
    end

    assign w_lut = r_lut;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{cfg_we, cfg_lut};
    assign w_lut        = TRUTH_TABLE;
`endif

    assign w_sat = &r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0   <= 1'b0;
            r_s1   <= 1'b0;
            r_pass <= 1'b0;
            r_cnt  <= '0;
        end else if (reset_nos) begin
            r_s0   <= init_state;
            r_s1   <= init_state;
            r_pass <= 1'b1;
            r_cnt  <= '0;
        end else begin
            // Slow trajectory advances on every second strobe, gated by r_pass.
            if (start_s0) begin
                if (r_pass) begin
                    r_s0 <= w_lut[nb_s0];
                end
                r_pass <= ~r_pass;
            end
            if (start_s1) begin
                r_s1 <= w_lut[nb_s1];
                if (!w_sat) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign s0       = r_s0;
    assign s1       = r_s1;
    assign match    = (r_s0 == r_s1);
    assign step_cnt = r_cnt;
    assign step_sat = w_sat;

endmodule
`default_nettype wire
